uart_alu_cmd_ctrl: RTL
======================

# uart_alu_cmd_ctrl

- Parametrised command controller between a byte-wide UART receiver/transmitter pair and the ALU.
- Decodes a command-byte protocol that loads multi-byte operands A and B and an opcode, then executes and returns the multi-byte result plus a status byte.
- Generalises the single-byte command interface to N-bit operands, with atomic operand commit, an inter-byte timeout, NAK on unknown commands and transmit backpressure.

## Interface
- N, 8: operand/result width in bits; multiple of 8, range 8..32; NB = N/8 bytes per operand.
- OP_W, 6: ALU opcode width.
- TIMEOUT_CYC, 1_000_000: max clk cycles allowed between operand bytes before the load is aborted.
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only when rx_valid is high.
- rx_valid  in  1  one-cycle pulse per received byte.
- tx_ready  in  1  UART transmitter idle; drops the cycle after a byte is accepted.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  one-cycle start pulse; only ever asserted while tx_ready = 1.
- alu_a  out  N  committed operand A.
- alu_b  out  N  committed operand B.
- alu_op  out  OP_W  committed opcode.
- alu_result  in  N  combinational ALU result.
- alu_carry  in  1  ALU carry flag.
- alu_zero  in  1  ALU zero flag.
- busy  out  1  high in every state except IDLE.

## Operation
- Command codes:
  - 0x01: load A, followed by NB bytes, LSB first.
  - 0x02: load B, followed by NB bytes, LSB first.
  - 0x03: set opcode, followed by 1 byte; the low OP_W bits are used.
  - 0x04: execute.
  - Any other code: NAK, transmits 0xEE.
- States:
  - IDLE: a byte is taken as a command. 0x01/0x02/0x03 → LOAD; 0x04 → EXEC; other → TX_SEND with a single NAK byte.
  - LOAD: each rx_valid byte shifts into a shadow register at position byte_cnt. After the last byte the shadow is committed to alu_a, alu_b or alu_op in one cycle, then → IDLE. Targets are never partially updated.
  - EXEC: one cycle. Captures alu_result and status byte {6'b0, alu_carry, alu_zero} into the response buffer, sets response length to NB+1, then → TX_SEND.
  - TX_SEND: when tx_ready = 1, drive tx_data with the next response byte (result LSB first, status byte last) and pulse tx_valid, then → TX_WAIT.
  - TX_WAIT: ignore tx_ready in the cycle after the pulse, then wait for tx_ready = 1. → TX_SEND if bytes remain, else → IDLE.
- rx_valid in EXEC, TX_SEND or TX_WAIT: the byte is dropped, with no side effect.
- Timeout: the counter is cleared on entering LOAD and on every accepted byte. On reaching TIMEOUT_CYC, → IDLE with the shadow discarded, targets unchanged and nothing transmitted.
- rx_valid in the same cycle as timeout expiry: the byte wins and the counter clears.

## Timing
- Reset values: alu_a, alu_b, alu_op = 0; tx_data = 0x00; tx_valid = 0; busy = 0; state = IDLE; counters = 0.
- Reset asserted mid-operation aborts everything in the same cycle. No partial commit, no further tx_valid.
- Load commit: the target register updates on the clock edge after the cycle carrying the last operand byte's rx_valid.
- Execute latency with tx_ready held high:
  - cycle t: rx_valid with 0x04;
  - t+1: EXEC;
  - t+2: first tx_valid.
- NAK latency: tx_valid at t+1 after the unknown command byte, when tx_ready = 1.
- With tx_ready held low, tx_valid is held off indefinitely. Byte order and content do not change.
- The operand values used by EXEC are the committed values at cycle t+1.

## Structure
- Package uart_cmd_pkg holds:
  - command code localparams (CMD_LOAD_A, CMD_LOAD_B, CMD_SET_OP, CMD_EXEC);
  - NAK_BYTE = 8'hEE;
  - the state enum (IDLE, LOAD, EXEC, TX_SEND, TX_WAIT).
- One sub-module, resp_serializer:
  - holds the (NB+1)-byte response buffer, byte index and the TX_SEND/TX_WAIT handshake;
  - has load/len inputs and a done output.

## Test plan
1. N=16. Send 01 05 00, 02 03 00, 03 20, 04, with an ALU model where op 0x20 = add. Expect alu_a=0x0005, alu_b=0x0003, alu_op=0x20, and tx bytes 08 00 00 in order.
2. N=16. A=0xFFFF, B=0x0001, add, execute. Expect tx 00 00 03 (carry=1, zero=1).
3. Send 0x7F. Expect exactly one tx byte 0xEE, busy returns to 0, alu_* unchanged.
4. Send 01 34, then silence for TIMEOUT_CYC+10 cycles. Expect alu_a still 0x0000 and no tx. Next byte 0x02 is decoded as a command.
5. After 04, hold tx_ready low for 200 cycles. Expect no tx_valid while low, then NB+1 bytes correctly ordered. Extra rx bytes injected during TX are dropped.
6. Send 01 AA, then pulse reset for one cycle. Expect all outputs at reset values and busy=0. A following 01 11 22 loads alu_a=0x2211.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command controller: command codes,
// the NAK byte, the controller state encoding and small helpers.
package uart_cmd_pkg;

   // Command bytes recognised in IDLE
   localparam logic [7:0] CMD_LOAD_A = 8'h01;
   localparam logic [7:0] CMD_LOAD_B = 8'h02;
   localparam logic [7:0] CMD_SET_OP = 8'h03;
   localparam logic [7:0] CMD_EXEC   = 8'h04;

   // Reply to any unrecognised command byte
   localparam logic [7:0] NAK_BYTE   = 8'hEE;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      EXEC,
      TX_SEND,
      TX_WAIT
   } state_t;

   // Register a LOAD sequence is filling
   typedef enum logic [1:0] {
      TGT_A,
      TGT_B,
      TGT_OP
   } target_t;

   // Status byte returned after the result: {6'b0, carry, zero}
   function automatic logic [7:0] status_byte(input logic carry, input logic zero);
      return {6'b000000, carry, zero};
   endfunction

   function automatic logic is_known_cmd(input logic [7:0] code);
      return (code == CMD_LOAD_A) || (code == CMD_LOAD_B) ||
             (code == CMD_SET_OP) || (code == CMD_EXEC);
   endfunction

endpackage

// File: rtl/resp_serializer.sv
// Response serializer: captures up to NB+1 bytes in one cycle and streams
// them LSB first to a byte UART transmitter using the ready/valid handshake.
// tx_valid is gated directly by tx_ready so it can never fire while the
// transmitter is busy; the cycle after each pulse tx_ready is ignored
// because the transmitter only drops it one cycle late.
module resp_serializer
   import uart_cmd_pkg::*;
#(
   parameter int NB = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load,
   input  logic [$clog2(NB+2)-1:0]   len,
   input  logic [8*(NB+1)-1:0]       din,
   input  logic                      tx_ready,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   output logic                      next_byte,
   output logic                      done
);

   localparam int LEN_W = $clog2(NB+2);

   state_t             st;
   logic [7:0]         rbuf [0:NB];
   logic [LEN_W-1:0]   idx;
   logic [LEN_W-1:0]   len_r;
   logic               skip;
   logic               last;
   logic               wait_ok;

   assign last      = (idx == len_r);
   assign wait_ok   = (st == TX_WAIT) && !skip && tx_ready;
   assign tx_valid  = (st == TX_SEND) && tx_ready;
   assign next_byte = wait_ok && !last;
   assign done      = wait_ok && last;

   // Select the byte at the current index; idle output is 0x00
   always_comb begin
      tx_data = 8'h00;
      if (st == TX_SEND || st == TX_WAIT) begin
         for (int i = 0; i <= NB; i++) begin
            if (idx == LEN_W'(i)) tx_data = rbuf[i];
         end
      end
   end

   // Response buffer capture (datapath, no reset needed)
   always_ff @(posedge clk) begin
      if (load && st == IDLE) begin
         for (int i = 0; i <= NB; i++) rbuf[i] <= din[8*i +: 8];
      end
   end

   // Handshake sequencer: SEND pulses one byte, WAIT lets the transmitter finish
   always_ff @(posedge clk) begin
      if (reset) begin
         st    <= IDLE;
         idx   <= '0;
         len_r <= '0;
         skip  <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               if (load) begin
                  idx   <= '0;
                  len_r <= len;
                  st    <= TX_SEND;
               end
            end
            TX_SEND: begin
               if (tx_ready) begin
                  idx  <= idx + 1'b1;
                  skip <= 1'b1;
                  st   <= TX_WAIT;
               end
            end
            TX_WAIT: begin
               if (skip) begin
                  skip <= 1'b0;
               end else if (tx_ready) begin
                  st <= last ? IDLE : TX_SEND;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_alu_cmd_ctrl.sv
// Command controller between a byte UART and an N-bit ALU. Decodes
// load-A / load-B / set-opcode / execute commands, assembles multi-byte
// operands in a shadow register so the ALU inputs only ever change
// atomically, aborts stalled loads after TIMEOUT_CYC idle cycles, NAKs
// unknown commands and returns result bytes plus a status byte.
module uart_alu_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int N           = 8,
   parameter int OP_W        = 6,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   input  logic            tx_ready,
   output logic [7:0]      tx_data,
   output logic            tx_valid,
   output logic [N-1:0]    alu_a,
   output logic [N-1:0]    alu_b,
   output logic [OP_W-1:0] alu_op,
   input  logic [N-1:0]    alu_result,
   input  logic            alu_carry,
   input  logic            alu_zero,
   output logic            busy
);

   localparam int NB    = N / 8;
   localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;
   localparam int LEN_W = $clog2(NB + 2);
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [BC_W-1:0]  LAST_OPND = BC_W'(NB - 1);
   localparam logic [BC_W-1:0]  LAST_OPC  = '0;
   localparam logic [LEN_W-1:0] RESP_LEN  = LEN_W'(NB + 1);
   localparam logic [LEN_W-1:0] NAK_LEN   = LEN_W'(1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

   state_t                state;
   target_t               tgt;
   logic [BC_W-1:0]       byte_cnt;
   logic [BC_W-1:0]       last_cnt;
   logic [TMO_W-1:0]      tmo_cnt;
   logic [N-1:0]          shadow;
   logic [N-1:0]          shadow_nxt;

   logic                  ser_load;
   logic [LEN_W-1:0]      ser_len;
   logic [8*(NB+1)-1:0]   ser_din;
   logic                  ser_next;
   logic                  ser_done;

   assign busy = (state != IDLE);

   // Shadow with the incoming byte merged at byte_cnt, so commit needs no extra cycle
   always_comb begin
      shadow_nxt = shadow;
      for (int i = 0; i < NB; i++) begin
         if (byte_cnt == BC_W'(i)) shadow_nxt[8*i +: 8] = rx_data;
      end
   end

   // Serializer launch: full response from EXEC, single NAK byte from IDLE
   always_comb begin
      ser_load = 1'b0;
      ser_len  = NAK_LEN;
      ser_din  = {{(8*NB){1'b0}}, NAK_BYTE};
      if (state == EXEC) begin
         ser_load = 1'b1;
         ser_len  = RESP_LEN;
         ser_din  = {status_byte(alu_carry, alu_zero), alu_result};
      end else if (state == IDLE && rx_valid && !is_known_cmd(rx_data)) begin
         ser_load = 1'b1;
      end
   end

   // Command FSM: decode, operand assembly with timeout, atomic commit, tx sequencing
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tgt      <= TGT_A;
         byte_cnt <= '0;
         last_cnt <= '0;
         tmo_cnt  <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rx_valid) begin
                  byte_cnt <= '0;
                  tmo_cnt  <= '0;
                  shadow   <= '0;
                  case (rx_data)
                     CMD_LOAD_A: begin
                        tgt      <= TGT_A;
                        last_cnt <= LAST_OPND;
                        state    <= LOAD;
                     end
                     CMD_LOAD_B: begin
                        tgt      <= TGT_B;
                        last_cnt <= LAST_OPND;
                        state    <= LOAD;
                     end
                     CMD_SET_OP: begin
                        tgt      <= TGT_OP;
                        last_cnt <= LAST_OPC;
                        state    <= LOAD;
                     end
                     CMD_EXEC: state <= EXEC;
                     default:  state <= TX_SEND;
                  endcase
               end
            end
            LOAD: begin
               if (rx_valid) begin
                  tmo_cnt <= '0;
                  shadow  <= shadow_nxt;
                  if (byte_cnt == last_cnt) begin
                     case (tgt)
                        TGT_A:   alu_a  <= shadow_nxt;
                        TGT_B:   alu_b  <= shadow_nxt;
                        default: alu_op <= shadow_nxt[OP_W-1:0];
                     endcase
                     state <= IDLE;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            EXEC: state <= TX_SEND;
            TX_SEND: begin
               if (tx_ready) state <= TX_WAIT;
            end
            TX_WAIT: begin
               if (ser_done)      state <= IDLE;
               else if (ser_next) state <= TX_SEND;
            end
            default: state <= IDLE;
         endcase
      end
   end

   resp_serializer #(
      .NB (NB)
   ) u_resp (
      .clk       (clk),
      .reset     (reset),
      .load      (ser_load),
      .len       (ser_len),
      .din       (ser_din),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .next_byte (ser_next),
      .done      (ser_done)
   );

endmodule
